secuenciador: RTL

SECUENCIADOR -- requirements
Module: secuenciador

---
 rtl/secuenciador_pkg.sv | 28 ++
 rtl/secuenciador_if.sv | 34 +++
 rtl/secuenciador_lat_cnt.sv | 31 +++
 rtl/secuenciador.sv | 123 ++++++++++++
 4 files changed

// File: rtl/secuenciador_pkg.sv
// Shared definitions for the secuenciador instruction sequencer.
// Contents: FSM state encoding, opcode constants, decoder PC-enable (HAB)
// codes and a small helper that classifies conditional-branch HAB codes.
package secuenciador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_e;

  localparam logic [2:0] OP_HALT  = 3'b000;
  localparam logic [2:0] OP_BR    = 3'b111;

  localparam logic [2:0] HAB_JMP  = 3'b001;
  localparam logic [2:0] HAB_BRZ  = 3'b010;
  localparam logic [2:0] HAB_BRCZ = 3'b011;

  localparam int LAT_W = 3;

  function automatic logic is_cond_branch(input logic [2:0] hab);
    return (hab == HAB_BRZ) || (hab == HAB_BRCZ);
  endfunction

endpackage

// File: rtl/secuenciador_if.sv
// Bus bundle between the sequencer and its environment (program memory,
// control decoder, ALU flags).
//   slave  : the sequencer side (takes run/memory/decoder/flag inputs,
//            drives address, read strobe and decoder-facing outputs)
//   master : the environment side
interface secuenciador_if #(
  parameter int PC_W = 5
);
  logic            run;
  logic [7:0]      mem_data;
  logic            done;
  logic [2:0]      hab;
  logic            flag_we;
  logic            flag_z;
  logic            flag_c;

  logic [PC_W-1:0] pc_addr;
  logic            mem_rd;
  logic [2:0]      inst;
  logic [1:0]      cond;
  logic [4:0]      oper;
  logic            exec_v;
  logic            halted;

  modport slave (
    input  run, mem_data, done, hab, flag_we, flag_z, flag_c,
    output pc_addr, mem_rd, inst, cond, oper, exec_v, halted
  );

  modport master (
    output run, mem_data, done, hab, flag_we, flag_z, flag_c,
    input  pc_addr, mem_rd, inst, cond, oper, exec_v, halted
  );
endinterface

// File: rtl/secuenciador_lat_cnt.sv
// Program-memory latency down-counter.
// Ports: clk, rst_n (async, active-low); load_i/load_val_i load the count;
// dec_i decrements it; zero_o flags that the decrement taken this cycle
// lands on zero (count is 1, or already 0), so the FSM can leave WAIT on
// the same edge instead of spending an extra cycle observing zero.
module sec_lat_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q <= W'(1));

endmodule

// File: rtl/secuenciador.sv
// Instruction sequencer: fetches an 8-bit word from program memory,
// waits out the memory latency, latches it into IR and presents it to an
// external combinational control decoder for one execute cycle, then
// updates the PC from the decoder's HAB/DONE response.
// Ports: clk, rst_n (async, active-low), bus (secuenciador_if.slave).
// Parameters: PC_W program-counter width, MEM_LAT memory latency (1..7).
//
// state  | meaning
// IDLE   | waiting for run after reset
// FETCH  | address driven, mem_rd pulsed, latency counter loaded
// WAIT   | counting remaining memory latency cycles
// DECODE | memory word latched into IR
// EXEC   | opcode/operand presented, decoder response sampled, PC updated
// HALT   | halt opcode executed; run restarts from address 0
module secuenciador
  import secuenciador_pkg::*;
#(
  parameter int PC_W    = 5,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  secuenciador_if.slave  bus
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      ir_q;
  logic [1:0]      flags_q;   // {C, Z}
  logic            mem_rd_q;
  logic [2:0]      inst_q;
  logic            exec_v_q;
  logic            halted_q;
  logic            cnt_zero;

  sec_lat_cnt #(.W(LAT_W)) u_lat_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (state_q == ST_FETCH),
    .load_val_i (LAT_LOAD),
    .dec_i      (state_q == ST_WAIT),
    .zero_o     (cnt_zero)
  );

  // Outputs are registered: each is set on the edge that enters the state
  // it belongs to, so it is valid for the whole of that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      flags_q  <= '0;
      mem_rd_q <= 1'b0;
      inst_q   <= OP_HALT;
      exec_v_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      // The flag write lands at the end of the cycle, so a branch in the
      // same EXEC cycle still evaluates against the old flags.
      if (bus.flag_we) flags_q <= {bus.flag_c, bus.flag_z};

      mem_rd_q <= 1'b0;
      inst_q   <= OP_HALT;
      exec_v_q <= 1'b0;
      halted_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.run) begin
            state_q  <= ST_FETCH;
            mem_rd_q <= 1'b1;
          end
        end
        ST_FETCH: begin
          state_q <= (MEM_LAT > 1) ? ST_WAIT : ST_DECODE;
        end
        ST_WAIT: begin
          if (cnt_zero) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          ir_q     <= bus.mem_data;
          inst_q   <= bus.mem_data[7:5];
          exec_v_q <= 1'b1;
          state_q  <= ST_EXEC;
        end
        ST_EXEC: begin
          if (ir_q[7:5] == OP_HALT) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= ST_FETCH;
            mem_rd_q <= 1'b1;
            if ((bus.hab == HAB_JMP) || (is_cond_branch(bus.hab) && bus.done))
              pc_q <= PC_W'(ir_q[4:0]);
            else
              pc_q <= pc_q + PC_W'(1);
          end
        end
        ST_HALT: begin
          if (bus.run) begin
            pc_q     <= '0;
            state_q  <= ST_FETCH;
            mem_rd_q <= 1'b1;
          end else begin
            halted_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc_addr = pc_q;
  assign bus.mem_rd  = mem_rd_q;
  assign bus.inst    = inst_q;
  assign bus.cond    = flags_q;
  assign bus.oper    = ir_q[4:0];
  assign bus.exec_v  = exec_v_q;
  assign bus.halted  = halted_q;

endmodule
